uart_tx: RTL and testbench

Parameterised UART transmitter: accepts a parallel byte with a one-cycle valid strobe, then serialises a start bit, DATA_WIDTH data bits LSB first, an optional even/odd parity bit and one stop bit on TX_OUT. CLK runs at the bit rate, so one line bit lasts one CLK cycle. The block is the transmit half of the UART link and produces the frame format the receive side decodes. All outputs are registered.

---
 rtl/uart_tx.sv | 106 ++++++++++
 tb/tb_uart_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// CLK runs at the bit rate; TX_OUT and Busy are registered from the next state.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] par_data;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  par_en;
    logic                  par_typ;
    logic [CNT_W-1:0]      bit_cnt;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // shift_reg[0] is the data bit currently on the line, so the next one sits at bit 1
    assign shift_nxt = shift_reg >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            par_data  <= '0;
            par_en    <= 1'b0;
            par_typ   <= 1'b0;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            case (state)
                // STOP accepts exactly like IDLE so frames can run back to back
                IDLE, STOP: begin
                    if (Data_Valid) begin
                        state     <= START;
                        shift_reg <= P_DATA;
                        par_data  <= P_DATA;
                        par_en    <= PAR_EN;
                        par_typ   <= PAR_TYP;
                        bit_cnt   <= '0;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        Busy   <= 1'b0;
                    end
                end
                START: begin
                    state  <= DATA;
                    TX_OUT <= shift_reg[0];
                    Busy   <= 1'b1;
                end
                DATA: begin
                    shift_reg <= shift_nxt;
                    Busy      <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en) begin
                            state  <= PARITY;
                            TX_OUT <= parity_bit(par_data, par_typ);
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        TX_OUT  <= shift_nxt[0];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: queue-based line model checked every cycle, plus literal frame checks.
module tb_uart_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Model: queue of line bits still to be shown; its front is the bit on the line now.
    bit line_q[$];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            line_q.delete();
        end else begin
            int sz;
            sz = line_q.size();
            if (sz > 0) void'(line_q.pop_front());
            if (sz <= 1 && Data_Valid) begin
                line_q.push_back(1'b0);
                for (int i = 0; i < W; i++) line_q.push_back(P_DATA[i]);
                if (PAR_EN) line_q.push_back((^P_DATA) ^ PAR_TYP);
                line_q.push_back(1'b1);
            end
        end
    end

    always @(negedge CLK) begin
        if (line_q.size() > 0) begin
            chk("model_tx", {31'd0, TX_OUT}, {31'd0, line_q[0]});
            chk("model_busy", {31'd0, Busy}, 32'd1);
        end else begin
            chk("model_tx_idle", {31'd0, TX_OUT}, 32'd1);
            chk("model_busy_idle", {31'd0, Busy}, 32'd0);
        end
    end

    // Accept one word, optionally inject a second strobe at cycle inj, record n cycles.
    task automatic run_lit(input string name, input logic [W-1:0] d, input logic pen,
                           input logic ptyp, input int n, input logic [31:0] exp_tx,
                           input logic [31:0] exp_busy, input int inj,
                           input logic [W-1:0] inj_d);
        logic [31:0] seq;
        logic [31:0] bsy;
        seq = '0;
        bsy = '0;
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            seq = {seq[30:0], TX_OUT};
            bsy = {bsy[30:0], Busy};
            if (i == inj) begin
                Data_Valid = 1'b1;
                P_DATA = inj_d;
            end
        end
        chk({name, "_tx"}, seq, exp_tx);
        chk({name, "_busy"}, bsy, exp_busy);
    endtask

    task automatic idle_check(input string name);
        @(negedge CLK);
        Data_Valid = 1'b0;
        chk({name, "_idle_tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({name, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_tx", {31'd0, TX_OUT}, 32'd1);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        #2 RST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_hold_tx", {31'd0, TX_OUT}, 32'd1);
            chk("idle_hold_busy", {31'd0, Busy}, 32'd0);
        end

        run_lit("a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 32'b0101001011, 32'h3FF, -1, '0);
        idle_check("a5_nopar");
        run_lit("a5_even", 8'hA5, 1'b1, 1'b0, 11, 32'b01010010101, 32'h7FF, -1, '0);
        idle_check("a5_even");
        run_lit("a5_odd", 8'hA5, 1'b1, 1'b1, 11, 32'b01010010111, 32'h7FF, -1, '0);
        idle_check("a5_odd");
        run_lit("07_even", 8'h07, 1'b1, 1'b0, 11, 32'b01110000011, 32'h7FF, -1, '0);
        idle_check("07_even");

        run_lit("b2b", 8'h3C, 1'b0, 1'b0, 20, 32'b00011110010111111111, 32'hFFFFF, 9, 8'hFF);
        idle_check("b2b");

        run_lit("disturb", 8'h5A, 1'b0, 1'b0, 12, 32'b001011010111, 32'b111111111100, 3, 8'h00);
        idle_check("disturb");

        // Reset during data bit 3 (cycle 4 of the frame)
        run_lit("pre_rst", 8'hA5, 1'b0, 1'b0, 5, 32'b01010, 32'h1F, -1, '0);
        #2 RST = 1'b0;
        #1;
        chk("rst_async_tx", {31'd0, TX_OUT}, 32'd1);
        chk("rst_async_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        run_lit("post_rst_81", 8'h81, 1'b0, 1'b0, 10, 32'b0100000011, 32'h3FF, -1, '0);
        idle_check("post_rst_81");

        // Random traffic: strobes land in every state, exercising accepts, ignores and back-to-back
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            Data_Valid = ($urandom_range(0, 2) == 0);
            P_DATA = W'($urandom);
            PAR_EN = $urandom_range(0, 1) == 1;
            PAR_TYP = $urandom_range(0, 1) == 1;
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (14) @(negedge CLK);
        chk("final_idle_tx", {31'd0, TX_OUT}, 32'd1);
        chk("final_idle_busy", {31'd0, Busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
